// File: rtl/pht_updater.sv
// pht_updater
//   Write-side controller for the pattern history table. Resolved-branch records
//   (PC, taken) are queued in a small FIFO, then each one is applied to the 2-bit
//   saturating counter at the gshare index (PC ^ GHR) with a read-modify-write.
//   The module owns the global history register.
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   upd_valid/ready  record handshake, transfer on valid & ready
//   upd_pc, upd_taken  branch PC (word aligned) and resolved direction
//   pht_addr         table index, stable from IDLE exit through WR
//   pht_wr_en        one-cycle write strobe in WR
//   pht_wr_data      updated counter value
//   pht_rd_data      table read data, valid one cycle after pht_addr
//   ghr              global history, LSB = newest outcome
//   busy             FSM active or queue non-empty
//   upd_count        completed updates, wraps at 16 bits
//
// state | meaning
// IDLE  | waiting; pops the queue head and drives the index
// RD    | table read in flight
// CAP   | read data valid; next counter value computed
// WR    | write strobe, history shift, completion count
module pht_updater #(
  parameter int ADDR_W     = 14,
  parameter int GHR_W      = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  output logic [ADDR_W-1:0] pht_addr,
  output logic              pht_wr_en,
  output logic [1:0]        pht_wr_data,
  input  logic [1:0]        pht_rd_data,
  output logic [GHR_W-1:0]  ghr,
  output logic              busy,
  output logic [15:0]       upd_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                taken_q, taken_d;
  logic [1:0]          nval_q, nval_d;
  logic [GHR_W-1:0]    ghr_q, ghr_d;
  logic [15:0]         count_q, count_d;

  // Only the index bits of the PC are needed, so only those are queued.
  logic [ADDR_W-1:0]   fifo_idx_q [FIFO_DEPTH];
  logic                fifo_tk_q  [FIFO_DEPTH];

  logic full, empty, push, pop;

  assign full      = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign upd_ready = !reset && !full;
  assign push      = upd_valid && upd_ready;
  assign pop       = (state_q == IDLE) && !empty;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    addr_d   = addr_q;
    taken_d  = taken_q;
    nval_d   = nval_q;
    ghr_d    = ghr_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          addr_d  = fifo_idx_q[rd_ptr_q] ^ ADDR_W'(ghr_q);
          taken_d = fifo_tk_q[rd_ptr_q];
          state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (taken_q) nval_d = (pht_rd_data == 2'd3) ? 2'd3 : pht_rd_data + 2'd1;
        else         nval_d = (pht_rd_data == 2'd0) ? 2'd0 : pht_rd_data - 2'd1;
        state_d = WR;
      end
      WR: begin
        ghr_d   = {ghr_q[GHR_W-2:0], taken_q};
        count_d = count_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      taken_q  <= 1'b0;
      nval_q   <= 2'd0;
      ghr_q    <= '0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      taken_q  <= taken_d;
      nval_q   <= nval_d;
      ghr_q    <= ghr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= upd_pc[ADDR_W+1:2];
      fifo_tk_q[wr_ptr_q]  <= upd_taken;
    end
  end

  // Gating with reset keeps a reset that lands in WR from reaching the table.
  assign pht_wr_en   = (state_q == WR) && !reset;
  assign pht_wr_data = nval_q;
  assign pht_addr    = addr_q;
  assign ghr         = ghr_q;
  assign upd_count   = count_q;
  assign busy        = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_pht_updater.sv
module tb_pht_updater;
  localparam int ADDR_W = 14;
  localparam int GHR_W  = 14;
  localparam int FD     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              upd_valid = 1'b0;
  logic              upd_ready;
  logic [31:0]       upd_pc = '0;
  logic              upd_taken = 1'b0;
  logic [ADDR_W-1:0] pht_addr;
  logic              pht_wr_en;
  logic [1:0]        pht_wr_data;
  logic [1:0]        pht_rd_data;
  logic [GHR_W-1:0]  ghr;
  logic              busy;
  logic [15:0]       upd_count;

  int n_tests = 0;
  int n_fail  = 0;

  pht_updater #(.ADDR_W(ADDR_W), .GHR_W(GHR_W), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .pht_addr(pht_addr),
    .pht_wr_en(pht_wr_en), .pht_wr_data(pht_wr_data), .pht_rd_data(pht_rd_data),
    .ghr(ghr), .busy(busy), .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  // Table memory: one-cycle read latency, preload port for directed cases.
  logic [1:0]        mem [1 << ADDR_W];
  logic              mem_init = 1'b0;
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [1:0]        pl_data = '0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 2'($urandom);
      mem_init <= 1'b1;
    end
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (pht_wr_en) mem[pht_addr] <= pht_wr_data;
    pht_rd_data <= mem[pht_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: records in acceptance order, applied one at a time.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } rec_t;

  rec_t             exp_q[$];
  logic [GHR_W-1:0] m_ghr = '0;
  logic [15:0]      m_cnt = '0;

  function automatic logic [1:0] sat(input logic [1:0] c, input logic tk);
    int v;
    v = tk ? int'(c) + 1 : int'(c) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  always @(negedge clk) begin
    rec_t r;
    logic [ADDR_W-1:0] idx;
    if (reset) begin
      chk("rst_wr_en", 32'(pht_wr_en), 0);
      chk("rst_ready", 32'(upd_ready), 0);
      exp_q.delete();
      m_ghr = '0;
      m_cnt = '0;
    end else begin
      chk("ghr", 32'(ghr), 32'(m_ghr));
      chk("upd_count", 32'(upd_count), 32'(m_cnt));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (pht_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr", 32'(pht_wr_en), 0);
        end else begin
          r   = exp_q.pop_front();
          idx = r.pc[ADDR_W+1:2] ^ ADDR_W'(m_ghr);
          chk("wr_addr", 32'(pht_addr), 32'(idx));
          chk("wr_data", 32'(pht_wr_data), 32'(sat(mem[idx], r.taken)));
          m_ghr = {m_ghr[GHR_W-2:0], r.taken};
          m_cnt = m_cnt + 16'd1;
        end
      end
      if (upd_valid && upd_ready) exp_q.push_back('{pc: upd_pc, taken: upd_taken});
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Push one record in the current cycle and return the negedge index of the write.
  task automatic push_one(input logic [31:0] pc, input logic tk, output int lat);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (pht_wr_en) begin lat = k; break; end
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 200) chk("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic directed(input logic [31:0] pc, input logic tk, input logic [ADDR_W-1:0] e_addr,
                          input logic [1:0] e_data, input logic [GHR_W-1:0] e_ghr);
    int lat;
    push_one(pc, tk, lat);
    chk("latency", 32'(lat), 4);
    chk("lit_addr", 32'(pht_addr), 32'(e_addr));
    chk("lit_data", 32'(pht_wr_data), 32'(e_data));
    @(posedge clk); #1;
    chk("lit_ghr", 32'(ghr), 32'(e_ghr));
  endtask

  initial begin
    int acc;
    logic last_ready, saw_wr;

    // Reset held two cycles
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t1_ready", 32'(upd_ready), 1);
    chk("t1_ghr", 32'(ghr), 0);
    chk("t1_count", 32'(upd_count), 0);
    chk("t1_wr_en", 32'(pht_wr_en), 0);
    chk("t1_addr", 32'(pht_addr), 0);
    chk("t1_wdata", 32'(pht_wr_data), 0);
    chk("t1_busy", 32'(busy), 0);
    @(posedge clk); #1;

    // Single update, saturation both ways, gshare indexing
    preload(14'd4, 2'd1);
    directed(32'h10, 1'b1, 14'd4, 2'd2, 14'h0001);
    preload(14'd5, 2'd3);
    directed(32'h10, 1'b1, 14'd5, 2'd3, 14'h0003);
    preload(14'd7, 2'd0);
    directed(32'h10, 1'b0, 14'd7, 2'd0, 14'h0006);
    preload(14'd15, 2'd2);
    directed(32'h24, 1'b0, 14'd15, 2'd1, 14'h000C);

    // Reset while the RMW sits in CAP
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    @(posedge clk); #1 upd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    saw_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (pht_wr_en) saw_wr = 1'b1;
    end
    chk("t6_no_wr", 32'(saw_wr), 0);
    chk("t6_ghr", 32'(ghr), 0);
    chk("t6_count", 32'(upd_count), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(upd_ready), 1);
    @(posedge clk); #1;

    // Back-pressure: six back-to-back offers
    acc = 0;
    last_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h100 + 32'(i) * 4; upd_taken = i[0];
      @(negedge clk);
      if (upd_ready) acc++;
      last_ready = upd_ready;
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
    chk("t5_accepted", 32'(acc), 5);
    chk("t5_ready_low", 32'(last_ready), 0);
    wait_idle();
    chk("t5_count", 32'(upd_count), 5);

    // Random traffic with occasional resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      upd_valid = ($urandom_range(2) != 0);
      upd_pc    = $urandom & 32'hFFFF_FFFC;
      upd_taken = 1'($urandom);
      reset     = ($urandom_range(499) == 0);
      @(posedge clk); #1;
    end
    upd_valid = 1'b0;
    reset = 1'b0;
    wait_idle();
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
